ofifo_drain: RTL and testbench

Drain controller on the read side of the output FIFO. It waits for a complete column vector of partial sums (every column non-empty), pops it, optionally applies ReLU per column, and writes the vector into the psum SRAM at consecutive addresses. It sits between the output FIFO and the psum SRAM write port and is launched by the top-level controller once per output tile.

---
 rtl/ofifo_drain.sv | 92 +++++++++
 tb/tb_ofifo_drain.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/ofifo_drain.sv
// ofifo_drain: pops full psum vectors from the output FIFO, applies optional ReLU and writes them to psum SRAM.
module ofifo_drain #(
  parameter int col = 8,
  parameter int bw = 16,
  parameter int addr_w = 11,
  parameter int cnt_w = 11
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [addr_w-1:0]     base_addr,
  input  logic [cnt_w-1:0]      num_vec,
  input  logic                  relu_en,
  input  logic                  fifo_valid,
  input  logic [col*bw-1:0]     fifo_out,
  output logic                  fifo_rd,
  output logic                  sram_cen,
  output logic                  sram_wen,
  output logic [addr_w-1:0]     sram_addr,
  output logic [col*bw-1:0]     sram_d,
  output logic                  busy,
  output logic                  done
);
  typedef enum logic [1:0] {IDLE, WAIT, CAP, FIN} state_t;
  state_t state_q, state_d;
  logic [cnt_w-1:0] k_q, k_d, num_q, num_d;
  logic [addr_w-1:0] base_q, base_d, addr_q, addr_d;
  logic relu_q, relu_d, we_q, we_d;
  logic [col*bw-1:0] d_q, d_d, relu_vec;
  always_comb begin
    relu_vec = fifo_out;
    for (int i = 0; i < col; i++)
      relu_vec[i*bw +: bw] = (relu_q && fifo_out[i*bw+bw-1]) ? '0 : fifo_out[i*bw +: bw];
  end
  // Pop only from WAIT so the FIFO's registered pop lands before fifo_valid is looked at again.
  assign fifo_rd = (state_q == WAIT) && fifo_valid && (k_q < num_q);
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    num_d = num_q;
    base_d = base_q;
    relu_d = relu_q;
    addr_d = addr_q;
    d_d = d_q;
    we_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        base_d = base_addr;
        num_d = num_vec;
        relu_d = relu_en;
        k_d = '0;
        state_d = (num_vec == '0) ? FIN : WAIT;
      end
      WAIT: state_d = fifo_rd ? CAP : WAIT;
      CAP: begin
        d_d = relu_vec;
        addr_d = base_q + addr_w'(k_q);
        we_d = 1'b1;
        k_d = k_q + 1'b1;
        state_d = (k_d == num_q) ? FIN : WAIT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q <= '0;
      num_q <= '0;
      base_q <= '0;
      relu_q <= 1'b0;
      addr_q <= '0;
      d_q <= '0;
      we_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      num_q <= num_d;
      base_q <= base_d;
      relu_q <= relu_d;
      addr_q <= addr_d;
      d_q <= d_d;
      we_q <= we_d;
    end
  end
  assign sram_cen = ~we_q;
  assign sram_wen = ~we_q;
  assign sram_addr = addr_q;
  assign sram_d = d_q;
  assign busy = state_q != IDLE;
  assign done = state_q == FIN;
endmodule

// File: tb/tb_ofifo_drain.sv
// tb_ofifo_drain: directed bench for ofifo_drain with a small FIFO model and write monitor.
module tb_ofifo_drain;
  localparam int COL = 8, BW = 16, AW = 11, CW = 11;
  logic clk = 1'b0;
  logic reset, start, relu_en, fifo_valid, fifo_rd, sram_cen, sram_wen, busy, done;
  logic [AW-1:0] base_addr, sram_addr;
  logic [CW-1:0] num_vec;
  logic [COL*BW-1:0] fifo_out, sram_d;
  always #5 clk = ~clk;

  ofifo_drain #(.col(COL), .bw(BW), .addr_w(AW), .cnt_w(CW)) dut (
    .clk(clk), .reset(reset), .start(start), .base_addr(base_addr), .num_vec(num_vec),
    .relu_en(relu_en), .fifo_valid(fifo_valid), .fifo_out(fifo_out), .fifo_rd(fifo_rd),
    .sram_cen(sram_cen), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_d(sram_d),
    .busy(busy), .done(done)
  );

  logic [COL*BW-1:0] mem [16];
  logic [4:0] rp = '0, wp = '0;
  logic rd_q = 1'b0, gate = 1'b0, watch = 1'b0;
  assign fifo_valid = gate && (rp != wp);
  assign fifo_out = mem[rp[3:0]];
  // The FIFO applies a pop one cycle after fifo_rd, independent of the drain's reset.
  always @(posedge clk) begin
    rd_q <= fifo_rd;
    if (rd_q) rp <= rp + 5'd1;
  end

  int cyc = 0, nw = 0, nd = 0, nr = 0, last_done = 0, bad_rd = 0, bad_busy = 0, bad_en = 0;
  logic [AW-1:0] wa [64];
  logic [COL*BW-1:0] wd [64];
  int wc [64];
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (!sram_cen && nw < 64) begin
      wa[nw] = sram_addr;
      wd[nw] = sram_d;
      wc[nw] = cyc;
      nw++;
    end
    if (sram_cen !== sram_wen) bad_en++;
    if (done) begin nd++; last_done = cyc; end
    if (fifo_rd) nr++;
    if (fifo_rd && !gate) bad_rd++;
    if (watch && !busy) bad_busy++;
  end

  int pass = 0, total = 0;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else pass++;
  endtask

  function automatic logic [COL*BW-1:0] mk(input int b);
    logic [COL*BW-1:0] v;
    for (int i = 0; i < COL; i++) v[i*BW +: BW] = 16'(b * 16 + i);
    return v;
  endfunction

  task automatic push(input logic [COL*BW-1:0] v);
    mem[wp[3:0]] = v;
    wp = wp + 5'd1;
  endtask

  task automatic go(input logic [AW-1:0] b, input logic [CW-1:0] n, input logic r, output int s);
    @(posedge clk); #1;
    base_addr = b; num_vec = n; relu_en = r; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s = cyc;
  endtask

  task automatic wait_done(input int nd0);
    int t = 0;
    while (nd == nd0 && t < 200) begin @(posedge clk); t++; end
    chk("done_seen", 128'(nd != nd0), 128'd1);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals();
    chk("rst_fifo_rd", 128'(fifo_rd), 128'd0);
    chk("rst_cen", 128'(sram_cen), 128'd1);
    chk("rst_wen", 128'(sram_wen), 128'd1);
    chk("rst_addr", 128'(sram_addr), 128'd0);
    chk("rst_d", 128'(sram_d), 128'd0);
    chk("rst_busy", 128'(busy), 128'd0);
    chk("rst_done", 128'(done), 128'd0);
  endtask

  logic [COL*BW-1:0] rv, rx;
  int s, w0, nd0, nr0, t;
  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; num_vec = '0; relu_en = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals();
    reset = 1'b0;
    gate = 1'b1;

    for (int i = 0; i < 4; i++) push(mk(i));
    w0 = nw; nd0 = nd; nr0 = nr;
    go(11'h010, 11'd4, 1'b0, s);
    wait_done(nd0);
    chk("single_nw", 128'(nw - w0), 128'd4);
    chk("single_nr", 128'(nr - nr0), 128'd4);
    chk("single_nd", 128'(nd - nd0), 128'd1);
    chk("single_done_lat", 128'(last_done - s), 128'd8);
    chk("single_wr_lat", 128'(wc[w0] - s), 128'd2);
    for (int i = 0; i < 4; i++) begin
      chk("single_addr", 128'(wa[w0+i]), 128'(11'h010 + i));
      chk("single_data", 128'(wd[w0+i]), 128'(mk(i)));
      if (i > 0) chk("single_gap", 128'(wc[w0+i] - wc[w0+i-1]), 128'd2);
    end
    chk("single_busy_end", 128'(busy), 128'd0);

    rv = {16'd3, 16'd1, 16'hFFFE, 16'h7FFF, 16'h8000, 16'd5, 16'd0, 16'hFFFF};
    rx = {16'd3, 16'd1, 16'h0000, 16'h7FFF, 16'h0000, 16'd5, 16'd0, 16'h0000};
    push(rv); push(rv);
    w0 = nw; nd0 = nd;
    go(11'h100, 11'd1, 1'b1, s);
    wait_done(nd0);
    chk("relu_on", 128'(wd[w0]), 128'(rx));
    nd0 = nd;
    go(11'h101, 11'd1, 1'b0, s);
    wait_done(nd0);
    chk("relu_off", 128'(wd[w0+1]), 128'(rv));
    chk("relu_addr", 128'(wa[w0+1]), 128'h101);

    push(mk(5));
    w0 = nw; nd0 = nd;
    go(11'h200, 11'd3, 1'b0, s);
    t = 0;
    while (nw == w0 && t < 50) begin @(posedge clk); t++; end
    chk("stall_first_wr", 128'(nw - w0), 128'd1);
    gate = 1'b0; watch = 1'b1;
    push(mk(6)); push(mk(7));
    repeat (5) @(posedge clk);
    #1;
    gate = 1'b1; watch = 1'b0;
    wait_done(nd0);
    chk("stall_nw", 128'(nw - w0), 128'd3);
    chk("stall_no_rd", 128'(bad_rd), 128'd0);
    chk("stall_busy", 128'(bad_busy), 128'd0);
    for (int i = 0; i < 3; i++) begin
      chk("stall_addr", 128'(wa[w0+i]), 128'(11'h200 + i));
      chk("stall_data", 128'(wd[w0+i]), 128'(mk(5 + i)));
    end

    w0 = nw; nd0 = nd; nr0 = nr;
    go(11'h055, 11'd0, 1'b0, s);
    wait_done(nd0);
    chk("zero_done_lat", 128'(last_done - s), 128'd0);
    chk("zero_nw", 128'(nw - w0), 128'd0);
    chk("zero_nr", 128'(nr - nr0), 128'd0);

    push(mk(8)); push(mk(9));
    w0 = nw; nd0 = nd;
    go(11'h7FF, 11'd2, 1'b0, s);
    wait_done(nd0);
    chk("wrap_a0", 128'(wa[w0]), 128'h7FF);
    chk("wrap_a1", 128'(wa[w0+1]), 128'h000);
    chk("wrap_d1", 128'(wd[w0+1]), 128'(mk(9)));

    for (int i = 0; i < 4; i++) push(mk(10 + i));
    w0 = nw; nd0 = nd;
    go(11'h300, 11'd4, 1'b0, s);
    repeat (2) @(posedge clk);
    #1;
    base_addr = 11'h555; num_vec = 11'd1; relu_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(nd0);
    repeat (5) @(posedge clk);
    #1;
    chk("busy_start_nw", 128'(nw - w0), 128'd4);
    chk("busy_start_nd", 128'(nd - nd0), 128'd1);
    for (int i = 0; i < 4; i++) begin
      chk("busy_start_addr", 128'(wa[w0+i]), 128'(11'h300 + i));
      chk("busy_start_data", 128'(wd[w0+i]), 128'(mk(10 + i)));
    end

    for (int i = 0; i < 4; i++) push(mk(20 + i));
    w0 = nw; nd0 = nd;
    go(11'h400, 11'd4, 1'b0, s);
    t = 0;
    while (nw == w0 && t < 50) begin @(posedge clk); t++; end
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_vals();
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_nw", 128'(nw - w0), 128'd1);
    chk("rst_mid_nd", 128'(nd - nd0), 128'd0);
    w0 = nw; nd0 = nd;
    go(11'h480, 11'd1, 1'b0, s);
    wait_done(nd0);
    chk("rst_after_nw", 128'(nw - w0), 128'd1);
    chk("rst_after_addr", 128'(wa[w0]), 128'h480);
    chk("rst_after_data", 128'(wd[w0]), 128'(mk(22)));
    chk("cen_wen_equal", 128'(bad_en), 128'd0);

    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
